ppu_vram_arbiter: RTL and testbench
===================================

# ppu_vram_arbiter

Arbitrates the PPU's single-port VRAM (pattern, nametable, attribute space) between the background/sprite render fetch pipeline and the CPU-side PPUDATA ($2007) access port. Render fetches have priority; CPU accesses are buffered in a 2-entry queue and issued in free slots. Every VRAM access is issued from registered outputs, with read data routed back to the requester that issued it. The block sits between the PPU rendering FSMs and the VRAM/CHR memory instance.

## Interface
- `ADDR_W`, 14: VRAM address width ($0000-$3FFF).
- `MAX_WAIT`, 8: starvation limit in cycles. Used only when `VRAM_ARB_STARVE_EN` is defined.
- `PPU_SLOW_CLOCK`  in  1  Block clock. All logic is on the rising edge.
- `RST`  in  1  Reset: synchronous, active-high, on `PPU_SLOW_CLOCK`.
- `REN_REQ`  in  1  Render fetch request. Held with `REN_ADDR` stable until `REN_GNT`.
- `REN_ADDR`  in  14  Render fetch address (read only).
- `REN_GNT`  out  1  Render request accepted this cycle (combinational).
- `REN_RDATA`  out  8  Render read data.
- `REN_VALID`  out  1  `REN_RDATA` valid this cycle.
- `CPU_REQ`  in  1  CPU access request.
- `CPU_WE`  in  1  1 = write, 0 = read.
- `CPU_ADDR`  in  14  CPU access address.
- `CPU_WDATA`  in  8  CPU write data.
- `CPU_READY`  out  1  Queue can accept; a push occurs when `CPU_REQ` and `CPU_READY` are both high.
- `CPU_RDATA`  out  8  CPU read data.
- `CPU_VALID`  out  1  `CPU_RDATA` valid this cycle.
- `MEM_ADDR`  out  14  VRAM address (registered).
- `MEM_WE`  out  1  VRAM write strobe (registered).
- `MEM_WDATA`  out  8  VRAM write data (registered).
- `MEM_RDATA`  in  8  VRAM read data. The memory is synchronous and returns data 1 cycle after address.

## Operation
- CPU queue: 2-entry FIFO of {we, addr, wdata}. `CPU_READY` = (count < 2), computed from registered count.
  - Push and pop in the same cycle leaves count unchanged.
  - The queue never overflows and never underflows.
- Grant per cycle, combinational:
  - `gnt_ren = REN_REQ & ~force_cpu`
  - `gnt_cpu = ~gnt_ren & queue_nonempty`
  - Otherwise the cycle is idle.
  - At most one grant per cycle.
- Issue: on a grant, `MEM_ADDR`/`MEM_WE`/`MEM_WDATA` are registered from the winner. `MEM_WE` is high only for a CPU write. An idle cycle drives `MEM_WE` = 0 and holds `MEM_ADDR`.
- Address fold: addresses $3000-$3EFF map to $2000-$2EFF (bit 12 cleared). All other addresses pass unchanged.
- Read return: a 2-stage owner pipeline {valid, owner ∈ {REN, CPU}} tracks each read.
  - Writes enter the pipeline with valid = 0, so they produce no `CPU_VALID`.
  - At the return stage, `MEM_RDATA` is driven to `REN_RDATA` or `CPU_RDATA`, with the matching VALID high for 1 cycle.
  - The RDATA outputs hold their last value otherwise.
- Ordering: CPU accesses complete in FIFO order. A CPU write followed by a read of the same address returns the new data.
- States (issue FSM): IDLE, REN_ISSUE, CPU_ISSUE. The next state is set by the grant above; all three are reachable from each other.

## Timing
- Grant in cycle N → MEM_* valid in N+1 → `MEM_RDATA` in N+2 → VALID high in N+2. Read latency from grant is 2.
- CPU best case, with an empty queue and no render request: push in cycle N, grant in N+1, `CPU_VALID` in N+3.
- Back-to-back grants are allowed every cycle, giving a throughput of 1 access per cycle.
- Reset values: `MEM_ADDR`=0, `MEM_WE`=0, `MEM_WDATA`=0, `REN_RDATA`=0, `CPU_RDATA`=0, `REN_VALID`=0, `CPU_VALID`=0, `CPU_READY`=1. In the reset cycle, `REN_GNT`=0.
- Queue count resets to 0 and the owner pipeline resets to invalid.
- `RST` mid-operation: queued CPU accesses are discarded and in-flight reads are dropped (no VALID). The starvation counter is cleared.

## Configuration
- `VRAM_ARB_STARVE_EN` defined:
  - A wait counter (clog2(`MAX_WAIT`)+1 bits) increments each cycle the queue is non-empty and `gnt_cpu` = 0.
  - It clears on `gnt_cpu` or when the queue is empty.
  - When it reaches `MAX_WAIT`, `force_cpu` = 1 for exactly 1 cycle, and `REN_GNT` = 0 even if `REN_REQ` is high.
- `VRAM_ARB_STARVE_EN` not defined: `force_cpu` is tied to 0 and no counter is built. CPU accesses are served only in cycles where `REN_REQ` = 0.

## Structure
- `ppu_pkg` holds:
  - the `vram_req_t` struct {we, addr[13:0], wdata[7:0]};
  - the `vram_owner_e` enum {OWN_REN, OWN_CPU};
  - the `arb_state_e` enum;
  - the constants NT_MIRROR_BASE = 'h3000 and NT_MIRROR_END = 'h3EFF.
- One sub-module: `ppu_cpu_req_fifo`, a 2-deep FIFO of `vram_req_t` with push, pop, full and empty.

## Test plan
- `REN_REQ` held high with `REN_ADDR` = $1000, $1008, ... → `REN_GNT` high every cycle; `REN_VALID` each cycle from N+2 with data at the matching addresses.
- CPU write $2005 ← $AB, then read $2005, with `REN_REQ` = 0 → `MEM_WE` pulse with `MEM_ADDR` = $2005; `CPU_VALID` with `CPU_RDATA` = $AB 2 cycles after the read grant.
- CPU pushes 3 requests back-to-back while `REN_REQ` = 1 → `CPU_READY` falls after the 2nd push, and the 3rd is stalled until a slot frees.
- With `VRAM_ARB_STARVE_EN` and `MAX_WAIT` = 8, `REN_REQ` held high and 1 CPU read queued → exactly 1 cycle of `REN_GNT` = 0 after 8 waiting cycles; the CPU is granted there. Without the macro, the CPU is never granted.
- CPU read of $3123 → `MEM_ADDR` = $2123; CPU read of $3F05 → `MEM_ADDR` = $3F05.
- `RST` asserted 1 cycle after a CPU read grant with a 2nd request queued → no `CPU_VALID`; `CPU_READY` = 1 and all outputs at reset values on the following cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU VRAM arbiter slice.
// Latency: n/a (types, constants and one pure address-fold function).
// Backpressure: n/a.
// Contents: vram_req_t queued CPU access, vram_owner_e read owner,
//           arb_state_e issue FSM states, nametable mirror window bounds.
package ppu_pkg;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } vram_req_t;

    typedef enum logic {
        OWN_REN = 1'b0,
        OWN_CPU = 1'b1
    } vram_owner_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REN_ISSUE = 2'd1,
        CPU_ISSUE = 2'd2
    } arb_state_e;

    localparam logic [13:0] NT_MIRROR_BASE = 14'h3000;
    localparam logic [13:0] NT_MIRROR_END  = 14'h3EFF;

    // $3000-$3EFF mirrors the nametables at $2000-$2EFF; palette space
    // ($3F00-$3FFF) and everything else pass through untouched.
    function automatic logic [13:0] fold_addr(input logic [13:0] a);
        if ((a >= NT_MIRROR_BASE) && (a <= NT_MIRROR_END))
            return {a[13], 1'b0, a[11:0]};
        return a;
    endfunction

endpackage

// File: rtl/ppu_cpu_req_fifo.sv
// ppu_cpu_req_fifo: 2-deep queue of CPU VRAM requests.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: full_o from registered count; push while full or pop while empty is ignored.
// Ports: PPU_SLOW_CLOCK, RST (sync, active-high), push_i/push_dat_i,
//        pop_i, head_o, full_o, empty_o.
module ppu_cpu_req_fifo
    import ppu_pkg::*;
(
    input  logic      PPU_SLOW_CLOCK,
    input  logic      RST,
    input  logic      push_i,
    input  vram_req_t push_dat_i,
    input  logic      pop_i,
    output vram_req_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    vram_req_t  mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 2'd1;
        else if (do_pop && !do_push)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (RST) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (do_push && !RST)
            mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares single-port VRAM between render fetch (priority) and queued CPU PPUDATA accesses.
// Latency: grant N -> MEM_* N+1 -> read data with VALID in N+2; CPU push-to-grant 1 cycle minimum.
// Backpressure: render held by REN_GNT; CPU by CPU_READY (2-entry queue); reads cannot be stalled.
// Ports: REN_REQ/REN_ADDR -> REN_GNT, REN_RDATA/REN_VALID;
//        CPU_REQ/CPU_WE/CPU_ADDR/CPU_WDATA -> CPU_READY, CPU_RDATA/CPU_VALID;
//        MEM_ADDR/MEM_WE/MEM_WDATA registered to VRAM, MEM_RDATA back (1-cycle sync read).
// Option: define VRAM_ARB_STARVE_EN to force a CPU slot after MAX_WAIT waiting cycles.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
)
(
    input  logic              PPU_SLOW_CLOCK,
    input  logic              RST,
    input  logic              REN_REQ,
    input  logic [ADDR_W-1:0] REN_ADDR,
    output logic              REN_GNT,
    output logic [7:0]        REN_RDATA,
    output logic              REN_VALID,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [7:0]        CPU_WDATA,
    output logic              CPU_READY,
    output logic [7:0]        CPU_RDATA,
    output logic              CPU_VALID,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [7:0]        MEM_WDATA,
    input  logic [7:0]        MEM_RDATA
);

    vram_req_t   fifo_head;
    logic        fifo_full, fifo_empty;
    logic        gnt_ren, gnt_cpu, force_cpu;

    arb_state_e  state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;

    // Return stage of the owner pipeline; the issue stage is the FSM state
    // itself (REN_ISSUE, or CPU_ISSUE without a write strobe, is a read).
    logic        iss_rd_vld;
    vram_owner_e iss_owner;
    logic        ret_vld_q;
    vram_owner_e ret_own_q;
    logic [7:0]  ren_rdata_q, cpu_rdata_q;

    ppu_cpu_req_fifo u_cpu_fifo (
        .PPU_SLOW_CLOCK (PPU_SLOW_CLOCK),
        .RST            (RST),
        .push_i         (CPU_REQ),
        .push_dat_i     ('{we: CPU_WE, addr: CPU_ADDR, wdata: CPU_WDATA}),
        .pop_i          (gnt_cpu),
        .head_o         (fifo_head),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty)
    );

    assign CPU_READY = ~fifo_full;

`ifdef VRAM_ARB_STARVE_EN
    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q + 1'b1;
        if (fifo_empty || gnt_cpu)
            wait_d = '0;
    end

    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (RST)
            wait_q <= '0;
        else
            wait_q <= wait_d;
    end

    // The forced cycle grants the CPU, which clears the counter, so the
    // override lasts exactly one cycle.
    assign force_cpu = (wait_q == WAIT_W'(MAX_WAIT));
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign force_cpu       = 1'b0;
`endif

    // Grants are suppressed during reset so nothing is popped or issued.
    assign gnt_ren = REN_REQ & ~force_cpu & ~RST;
    assign gnt_cpu = ~gnt_ren & ~fifo_empty & ~RST;
    assign REN_GNT = gnt_ren;

    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (gnt_ren) begin
            state_d    = REN_ISSUE;
            mem_addr_d = fold_addr(REN_ADDR);
        end else if (gnt_cpu) begin
            state_d     = CPU_ISSUE;
            mem_addr_d  = fold_addr(fifo_head.addr);
            mem_we_d    = fifo_head.we;
            mem_wdata_d = fifo_head.wdata;
        end
    end

    assign iss_rd_vld = (state_q == REN_ISSUE) || ((state_q == CPU_ISSUE) && !mem_we_q);
    assign iss_owner  = (state_q == CPU_ISSUE) ? OWN_CPU : OWN_REN;

    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            ret_vld_q   <= 1'b0;
            ret_own_q   <= OWN_REN;
            ren_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            ret_vld_q   <= iss_rd_vld;
            ret_own_q   <= iss_owner;
            if (REN_VALID)
                ren_rdata_q <= MEM_RDATA;
            if (CPU_VALID)
                cpu_rdata_q <= MEM_RDATA;
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;

    // Memory data is forwarded straight through in its return cycle; the
    // captured copy holds the value between returns.
    assign REN_VALID = ret_vld_q & (ret_own_q == OWN_REN) & ~RST;
    assign CPU_VALID = ret_vld_q & (ret_own_q == OWN_CPU) & ~RST;
    assign REN_RDATA = REN_VALID ? MEM_RDATA : ren_rdata_q;
    assign CPU_RDATA = CPU_VALID ? MEM_RDATA : cpu_rdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: n/a (bench).
// Backpressure: honours REN_GNT hold rule and CPU_READY; emulates a 1-cycle synchronous VRAM.
module tb_ppu_vram_arbiter;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        RST;
    logic        REN_REQ;
    logic [13:0] REN_ADDR;
    logic        REN_GNT;
    logic [7:0]  REN_RDATA;
    logic        REN_VALID;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [13:0] CPU_ADDR;
    logic [7:0]  CPU_WDATA;
    logic        CPU_READY;
    logic [7:0]  CPU_RDATA;
    logic        CPU_VALID;
    logic [13:0] MEM_ADDR;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ppu_vram_arbiter #(.ADDR_W(14), .MAX_WAIT(MAXW)) dut (
        .PPU_SLOW_CLOCK (clk),
        .RST            (RST),
        .REN_REQ        (REN_REQ),
        .REN_ADDR       (REN_ADDR),
        .REN_GNT        (REN_GNT),
        .REN_RDATA      (REN_RDATA),
        .REN_VALID      (REN_VALID),
        .CPU_REQ        (CPU_REQ),
        .CPU_WE         (CPU_WE),
        .CPU_ADDR       (CPU_ADDR),
        .CPU_WDATA      (CPU_WDATA),
        .CPU_READY      (CPU_READY),
        .CPU_RDATA      (CPU_RDATA),
        .CPU_VALID      (CPU_VALID),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WE         (MEM_WE),
        .MEM_WDATA      (MEM_WDATA),
        .MEM_RDATA      (MEM_RDATA)
    );

    function automatic logic [7:0] pattern(input int a);
        return 8'(a & 'hff) ^ 8'((a >> 8) & 'h3f);
    endfunction

    function automatic logic [13:0] tb_fold(input logic [13:0] a);
        if (a >= 14'h3000 && a <= 14'h3EFF)
            return a - 14'h1000;
        return a;
    endfunction

    function automatic void check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s at %0t: got 'h%0h expected 'h%0h", nm, $time, got, exp);
        end
    endfunction

    // Synchronous VRAM: address/strobe seen at an edge, data out after it.
    logic [7:0] vram [16384];
    bit         vram_init = 0;
    always @(posedge clk) begin
        if (!vram_init) begin
            for (int i = 0; i < 16384; i++) vram[i] <= pattern(i);
            vram_init <= 1;
        end else begin
            if (MEM_WE) vram[MEM_ADDR] <= MEM_WDATA;
            MEM_RDATA <= vram[MEM_ADDR];
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } req_s;

    req_s        mq[$];
    logic [7:0]  shadow [16384];
    bit          shadow_init = 0;
    int          m_wait;
    logic [13:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata, exp_ren_rd, exp_cpu_rd;
    bit          r1_v, r1_cpu, r2_v, r2_cpu;
    logic [7:0]  r1_d, r2_d;

    always @(negedge clk) begin
        bit          ready, force_c, g_ren, g_cpu;
        int          qsz;
        logic [13:0] a;
        req_s        h;
        if (!shadow_init) begin
            for (int i = 0; i < 16384; i++) shadow[i] = pattern(i);
            shadow_init = 1;
        end
        if (RST) begin
            check("m_gnt_in_reset", REN_GNT, 0);
            mq.delete();
            m_wait = 0;
            exp_addr = 0; exp_we = 0; exp_wdata = 0;
            exp_ren_rd = 0; exp_cpu_rd = 0;
            r1_v = 0; r1_cpu = 0; r1_d = 0;
            r2_v = 0; r2_cpu = 0; r2_d = 0;
        end else begin
            qsz     = mq.size();
            ready   = (qsz < 2);
            force_c = 0;
`ifdef VRAM_ARB_STARVE_EN
            force_c = (m_wait == MAXW);
`endif
            g_ren = REN_REQ && !force_c;
            g_cpu = !g_ren && (qsz > 0);

            check("m_ren_gnt", REN_GNT, g_ren);
            check("m_cpu_ready", CPU_READY, ready);
            check("m_mem_addr", MEM_ADDR, exp_addr);
            check("m_mem_we", MEM_WE, exp_we);
            check("m_mem_wdata", MEM_WDATA, exp_wdata);
            check("m_ren_valid", REN_VALID, r2_v && !r2_cpu);
            check("m_cpu_valid", CPU_VALID, r2_v && r2_cpu);
            if (r2_v) begin
                if (r2_cpu) exp_cpu_rd = r2_d;
                else        exp_ren_rd = r2_d;
            end
            check("m_ren_rdata", REN_RDATA, exp_ren_rd);
            check("m_cpu_rdata", CPU_RDATA, exp_cpu_rd);

            r2_v = r1_v; r2_cpu = r1_cpu; r2_d = r1_d;
            r1_v = 0;
            if (g_ren) begin
                a = tb_fold(REN_ADDR);
                exp_addr = a; exp_we = 0;
                r1_v = 1; r1_cpu = 0; r1_d = shadow[a];
            end else if (g_cpu) begin
                h = mq.pop_front();
                a = tb_fold(h.addr);
                exp_addr = a; exp_we = h.we; exp_wdata = h.wdata;
                if (h.we) shadow[a] = h.wdata;
                else begin
                    r1_v = 1; r1_cpu = 1; r1_d = shadow[a];
                end
            end else begin
                exp_we = 0;
            end

            if (qsz > 0 && !g_cpu) m_wait++;
            else                   m_wait = 0;

            if (CPU_REQ && ready)
                mq.push_back('{we: CPU_WE, addr: CPU_ADDR, wdata: CPU_WDATA});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] rand_addr();
        case ($urandom % 4)
            0:       return 14'h2000 | 14'($urandom % 16);
            1:       return 14'h3000 | 14'($urandom % 16);
            2:       return 14'h3F00 | 14'($urandom % 16);
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        int low_cnt, low_at;
        bit seen, pend;
        int ren_pct, cpu_pct;
        RST = 1; REN_REQ = 0; REN_ADDR = 0;
        CPU_REQ = 0; CPU_WE = 0; CPU_ADDR = 0; CPU_WDATA = 0;
        repeat (3) step();
        REN_REQ = 1;
        @(negedge clk);
        check("gnt_in_reset", REN_GNT, 0);
        step();
        REN_REQ = 0; RST = 0;
        @(negedge clk);
        check("rst_mem_addr", MEM_ADDR, 0);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_mem_wdata", MEM_WDATA, 0);
        check("rst_cpu_ready", CPU_READY, 1);
        check("rst_ren_valid", REN_VALID, 0);
        check("rst_cpu_valid", CPU_VALID, 0);
        check("rst_ren_rdata", REN_RDATA, 0);
        check("rst_cpu_rdata", CPU_RDATA, 0);
        step();

        // Render stream $1000, $1008, ...
        for (int k = 0; k < 6; k++) begin
            REN_REQ = 1; REN_ADDR = 14'h1000 + 14'(8 * k);
            @(negedge clk);
            check("ren_stream_gnt", REN_GNT, 1);
            if (k >= 2) check("ren_stream_valid", REN_VALID, 1);
            if (k == 2) check("ren_rdata_1000", REN_RDATA, 8'h10);
            if (k == 3) check("ren_rdata_1008", REN_RDATA, 8'h18);
            step();
        end
        REN_REQ = 0;
        repeat (3) step();

        // CPU write $2005 <- $AB then read it back
        CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 14'h2005; CPU_WDATA = 8'hAB;
        step();
        CPU_WE = 0;
        step();
        CPU_REQ = 0;
        @(negedge clk);
        check("wr_mem_we", MEM_WE, 1);
        check("wr_mem_addr", MEM_ADDR, 14'h2005);
        check("wr_mem_wdata", MEM_WDATA, 8'hAB);
        step();
        @(negedge clk);
        check("wr_no_valid", CPU_VALID, 0);
        step();
        @(negedge clk);
        check("rd_cpu_valid", CPU_VALID, 1);
        check("rd_cpu_rdata", CPU_RDATA, 8'hAB);
        repeat (2) step();

        // Address fold
        CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 14'h3123;
        step();
        CPU_ADDR = 14'h3F05;
        step();
        CPU_REQ = 0;
        @(negedge clk);
        check("fold_3123", MEM_ADDR, 14'h2123);
        step();
        @(negedge clk);
        check("nofold_3f05", MEM_ADDR, 14'h3F05);
        repeat (3) step();

        // Three back-to-back pushes behind a busy renderer
        REN_REQ = 1; REN_ADDR = 14'h0400;
        CPU_REQ = 1; CPU_WE = 1; CPU_ADDR = 14'h2100; CPU_WDATA = 8'h11;
        @(negedge clk);
        check("q_ready0", CPU_READY, 1);
        step();
        CPU_ADDR = 14'h2101; CPU_WDATA = 8'h22;
        @(negedge clk);
        check("q_ready1", CPU_READY, 1);
        step();
        CPU_ADDR = 14'h2102; CPU_WDATA = 8'h33;
        @(negedge clk);
        check("q_full_ready", CPU_READY, 0);
        step();
        @(negedge clk);
        check("q_still_full", CPU_READY, 0);
        check("q_cpu_not_served", MEM_WE, 0);
        step();
        REN_REQ = 0;
        @(negedge clk);
        check("q_full_at_pop", CPU_READY, 0);
        step();
        @(negedge clk);
        check("q_slot_freed", CPU_READY, 1);
        step();
        CPU_REQ = 0;
        repeat (4) step();

        // Starvation window
        REN_REQ = 1; REN_ADDR = 14'h0800;
        CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 14'h0123;
        step();
        CPU_REQ = 0;
        low_cnt = 0; low_at = -1; seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!REN_GNT) begin
                low_cnt++;
                if (low_at < 0) low_at = i;
            end
            if (MEM_ADDR == 14'h0123) seen = 1;
            step();
        end
`ifdef VRAM_ARB_STARVE_EN
        check("starve_low_cycles", low_cnt, 1);
        check("starve_low_at", low_at, MAXW + 1);
        check("starve_cpu_served", seen, 1);
`else
        check("starve_low_cycles", low_cnt, 0);
        check("starve_cpu_served", seen, 0);
`endif
        REN_REQ = 0;
        repeat (3) step();

        // Reset one cycle after a CPU read grant, second request queued
        CPU_REQ = 1; CPU_WE = 0; CPU_ADDR = 14'h0555;
        step();
        CPU_ADDR = 14'h0666;
        step();
        CPU_REQ = 0; RST = 1;
        step();
        RST = 0;
        @(negedge clk);
        check("mrst_cpu_valid", CPU_VALID, 0);
        check("mrst_cpu_ready", CPU_READY, 1);
        check("mrst_mem_addr", MEM_ADDR, 0);
        check("mrst_mem_we", MEM_WE, 0);
        check("mrst_mem_wdata", MEM_WDATA, 0);
        check("mrst_ren_valid", REN_VALID, 0);
        check("mrst_cpu_rdata", CPU_RDATA, 0);
        check("mrst_ren_rdata", REN_RDATA, 0);
        step();
        @(negedge clk);
        check("mrst_no_valid1", CPU_VALID, 0);
        check("mrst_queue_dropped", MEM_ADDR, 0);
        step();
        @(negedge clk);
        check("mrst_no_valid2", CPU_VALID, 0);
        step();

        // Randomized traffic at varying densities
        pend = 0;
        for (int blk = 0; blk < 6; blk++) begin
            case (blk)
                0: ren_pct = 10;
                1: ren_pct = 50;
                2: ren_pct = 90;
                3: ren_pct = 100;
                4: ren_pct = 30;
                default: ren_pct = 0;
            endcase
            cpu_pct = int'($urandom_range(20, 90));
            for (int c = 0; c < 500; c++) begin
                if (!pend) begin
                    REN_REQ  = ($urandom_range(0, 99) < ren_pct);
                    REN_ADDR = rand_addr();
                end
                CPU_REQ   = ($urandom_range(0, 99) < cpu_pct);
                CPU_WE    = 1'($urandom % 2);
                CPU_ADDR  = rand_addr();
                CPU_WDATA = 8'($urandom);
                RST       = ($urandom_range(0, 299) == 0);
                @(negedge clk);
                pend = REN_REQ && !REN_GNT;
                step();
            end
        end
        RST = 0; REN_REQ = 0; CPU_REQ = 0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
